// File: rtl/argmax_pkg.sv
// Shared definitions for the pipelined argmax tree: node packing width,
// tie-break policy and the max/min selection encoding.
package argmax_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  // On equal values the node carrying the lower way index wins.
  localparam bit TIE_LOWER_PTR = 1'b1;

  // A tree node is packed as {valid, value, ptr}.
  function automatic int node_width(input int value_w, input int ptr_w);
    return 1 + value_w + ptr_w;
  endfunction

endpackage

// File: rtl/argmax_node.sv
// Combinational two-input tree node: picks the better of two {valid, value, ptr}
// nodes under the current max/min mode, breaking ties on the way index.
module argmax_node
  import argmax_pkg::*;
#(
  parameter int VALUE_W = 4,
  parameter int PTR_W   = 3,
  localparam int NODE_W = node_width(VALUE_W, PTR_W)
) (
  input  logic [NODE_W-1:0] a_node,
  input  logic [NODE_W-1:0] b_node,
  input  logic              mode,
  output logic [NODE_W-1:0] y_node
);

  logic               a_valid, b_valid;
  logic [VALUE_W-1:0] a_value, b_value;
  logic [PTR_W-1:0]   a_ptr, b_ptr;
  logic               a_better, a_wins_tie;

  assign {a_valid, a_value, a_ptr} = a_node;
  assign {b_valid, b_value, b_ptr} = b_node;

  always_comb begin
    a_better   = (mode == MODE_MIN) ? (a_value < b_value) : (a_value > b_value);
    a_wins_tie = TIE_LOWER_PTR ? (a_ptr < b_ptr) : (a_ptr > b_ptr);
    // NOTE: default assignment first so every path drives y_node and no latch is inferred.
    y_node = '0;
    if (a_valid && b_valid) begin
      y_node = (a_better || ((a_value == b_value) && a_wins_tie)) ? a_node : b_node;
    end else if (a_valid) begin
      y_node = a_node;
    end else if (b_valid) begin
      y_node = b_node;
    end
  end

endmodule

// File: rtl/pipelined_argmax.sv
// Pipelined argmax over NUM_WAY masked values, one register stage per tree layer.
// Optional feature macro: PIPELINED_ARGMAX_MIN_MODE_EN adds mode_in for per-request min selection.
module pipelined_argmax
  import argmax_pkg::*;
#(
  parameter int NUM_WAY                  = 8,
  parameter int SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int WAY_PTR_WIDTH_IN_BITS    = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1
) (
  input  logic                                        clk_in,
  input  logic                                        reset_in,
  input  logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0] way_flatted_in,
  input  logic [NUM_WAY-1:0]                          condition_in,
`ifdef PIPELINED_ARGMAX_MIN_MODE_EN
  input  logic                                        mode_in,
`endif
  input  logic                                        valid_in,
  output logic                                        ready_out,
  output logic                                        valid_out,
  input  logic                                        ready_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS-1:0]         select_out,
  output logic [WAY_PTR_WIDTH_IN_BITS-1:0]            ptr_out,
  output logic                                        found_out
);

  localparam int W           = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int P           = WAY_PTR_WIDTH_IN_BITS;
  localparam int DEPTH       = (NUM_WAY > 1) ? $clog2(NUM_WAY) : 1;
  localparam int LEAVES      = 1 << DEPTH;
  localparam int STAGE_NODES = LEAVES - 1;
  localparam int NODE_W      = node_width(W, P);
  localparam int ROOT        = LEAVES - 2;

  // Stage nodes are laid out layer after layer: stage k starts at this index.
  function automatic int stage_offset(input int k);
    return LEAVES - (LEAVES >> k);
  endfunction

  function automatic logic [DEPTH-1:0] lower_mask(input int k);
    logic [DEPTH-1:0] m;
    m = '0;
    for (int b = 0; b < k; b++) m[b] = 1'b1;
    return m;
  endfunction

  logic [NODE_W-1:0]      leaf_node  [LEAVES];
  logic [NODE_W-1:0]      comb_node  [STAGE_NODES];
  logic [NODE_W-1:0]      stage_node [STAGE_NODES];
  logic [STAGE_NODES-1:0] node_load;
  logic [DEPTH-1:0]       stage_valid;
  logic [DEPTH-1:0]       stage_load;
  logic [DEPTH-1:0]       layer_mode;
  logic [NODE_W-1:0]      root_node;

  // Leaves beyond NUM_WAY are permanently invalid, so they can never win.
  for (genvar i = 0; i < LEAVES; i++) begin : gen_leaf
    if (i < NUM_WAY) begin : gen_real
      assign leaf_node[i] = condition_in[i] ? {1'b1, way_flatted_in[i*W +: W], P'(i)} : '0;
    end else begin : gen_pad
      assign leaf_node[i] = '0;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : gen_layer
    localparam int OUT_OFF = stage_offset(k);
    localparam int N_OUT   = LEAVES >> (k + 1);
    for (genvar j = 0; j < N_OUT; j++) begin : gen_node
      logic [NODE_W-1:0] a_node, b_node;
      if (k == 0) begin : gen_from_leaf
        assign a_node = leaf_node[2*j];
        assign b_node = leaf_node[2*j+1];
      end else begin : gen_from_stage
        localparam int IN_OFF = stage_offset(k - 1);
        assign a_node = stage_node[IN_OFF+2*j];
        assign b_node = stage_node[IN_OFF+2*j+1];
      end
      argmax_node #(
        .VALUE_W(W),
        .PTR_W  (P)
      ) u_node (
        .a_node(a_node),
        .b_node(b_node),
        .mode  (layer_mode[k]),
        .y_node(comb_node[OUT_OFF+j])
      );
      assign node_load[OUT_OFF+j] = stage_load[k];
    end
  end

  // Stage k may load unless it and every stage after it are full while the
  // consumer stalls; this is the bubble-collapsing chain in closed form.
  always_comb begin
    stage_load = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stage_load[k] = ready_in || !(&(stage_valid | lower_mask(k)));
    end
  end

  assign ready_out = stage_load[0] && !reset_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      stage_valid <= '0;
    end else begin
      // NOTE: non-blocking so each stage samples its upstream's pre-edge value.
      if (stage_load[0]) stage_valid[0] <= valid_in;
      for (int k = 1; k < DEPTH; k++) begin
        if (stage_load[k]) stage_valid[k] <= stage_valid[k-1];
      end
    end
  end

  // NOTE: node data is not reset; every output derived from it is gated by a stage valid bit.
  always_ff @(posedge clk_in) begin
    for (int s = 0; s < STAGE_NODES; s++) begin
      if (node_load[s]) stage_node[s] <= comb_node[s];
    end
  end

`ifdef PIPELINED_ARGMAX_MIN_MODE_EN
  logic [DEPTH-1:0] stage_mode;

  always_ff @(posedge clk_in) begin
    if (stage_load[0]) stage_mode[0] <= mode_in;
    for (int k = 1; k < DEPTH; k++) begin
      if (stage_load[k]) stage_mode[k] <= stage_mode[k-1];
    end
  end

  // Each layer compares under the mode travelling with the request it is fed.
  always_comb begin
    layer_mode    = '0;
    layer_mode[0] = mode_in;
    for (int k = 1; k < DEPTH; k++) layer_mode[k] = stage_mode[k-1];
  end
`else
  always_comb begin
    layer_mode = '0;
    for (int k = 0; k < DEPTH; k++) layer_mode[k] = MODE_MAX;
  end
`endif

  assign root_node  = stage_node[ROOT];
  assign valid_out  = stage_valid[DEPTH-1];
  assign found_out  = valid_out && root_node[NODE_W-1];
  assign select_out = found_out ? root_node[P +: W] : '0;
  assign ptr_out    = found_out ? root_node[P-1:0] : '0;

endmodule

// File: tb/tb_pipelined_argmax.sv
// Self-checking bench for pipelined_argmax: an 8-way instance checked every cycle
// against a scan-based scoreboard model, plus a 5-way instance for padding/latency.
module tb_pipelined_argmax;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_in;
  logic [31:0] way8;
  logic [7:0]  cond8;
  logic        valid8, rdy8, mode8;
  logic        ready_out8, valid_out8, found8;
  logic [3:0]  sel8;
  logic [2:0]  ptr8;

  logic [19:0] way5;
  logic [4:0]  cond5;
  logic        valid5, rdy5;
  logic        ready_out5, valid_out5, found5;
  logic [3:0]  sel5;
  logic [2:0]  ptr5;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       hold_pending = 1'b0;
  logic [7:0] held;

  logic [31:0] bp_vals  [6] = '{32'h52709193, 32'hFFFFFFFF, 32'h01234567,
                                32'h89ABCDEF, 32'h11111111, 32'h7E7E1234};
  logic [7:0]  bp_masks [6] = '{8'hFF, 8'h80, 8'h0F, 8'h00, 8'hF0, 8'h5A};

  pipelined_argmax #(
    .NUM_WAY(8),
    .SINGLE_WAY_WIDTH_IN_BITS(4)
  ) dut8 (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .way_flatted_in(way8),
    .condition_in  (cond8),
`ifdef PIPELINED_ARGMAX_MIN_MODE_EN
    .mode_in       (mode8),
`endif
    .valid_in      (valid8),
    .ready_out     (ready_out8),
    .valid_out     (valid_out8),
    .ready_in      (rdy8),
    .select_out    (sel8),
    .ptr_out       (ptr8),
    .found_out     (found8)
  );

  pipelined_argmax #(
    .NUM_WAY(5),
    .SINGLE_WAY_WIDTH_IN_BITS(4)
  ) dut5 (
    .clk_in        (clk),
    .reset_in      (reset_in),
    .way_flatted_in(way5),
    .condition_in  (cond5),
`ifdef PIPELINED_ARGMAX_MIN_MODE_EN
    .mode_in       (1'b0),
`endif
    .valid_in      (valid5),
    .ready_out     (ready_out5),
    .valid_out     (valid_out5),
    .ready_in      (rdy5),
    .select_out    (sel5),
    .ptr_out       (ptr5),
    .found_out     (found5)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {found, value, ptr}: linear scan, first strictly better way wins.
  function automatic logic [7:0] model8(input logic [31:0] vals, input logic [7:0] mask,
                                        input logic mode);
    int best, bv, v;
    best = -1;
    bv   = 0;
    for (int i = 0; i < 8; i++) begin
      if (mask[i]) begin
        v = int'(vals[4*i +: 4]);
        if (best < 0 || (mode ? (v < bv) : (v > bv))) begin
          best = i;
          bv   = v;
        end
      end
    end
    if (best < 0) return 8'h00;
    return {1'b1, 4'(bv), 3'(best)};
  endfunction

  // Scoreboard: push on accept, pop on emit, verify hold while stalled.
  always @(negedge clk) begin
    if (reset_in) begin
      exp_q.delete();
      hold_pending = 1'b0;
    end else begin
      if (hold_pending) begin
        check("hold_valid", {31'd0, valid_out8}, 32'd1);
        check("hold_data", {24'd0, found8, sel8, ptr8}, {24'd0, held});
      end
      if (valid_out8 && rdy8) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", {31'd0, valid_out8}, 32'd0);
        end else begin
          check("result", {24'd0, found8, sel8, ptr8}, {24'd0, exp_q[0]});
          void'(exp_q.pop_front());
        end
      end
      hold_pending = valid_out8 && !rdy8;
      held         = {found8, sel8, ptr8};
      if (valid8 && ready_out8) exp_q.push_back(model8(way8, cond8, mode8));
    end
  end

  task automatic accept8(input string name);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ready_out8) break;
    end
    check({name, "_accept"}, {31'd0, ready_out8}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one8(input string name, input logic [31:0] vals, input logic [7:0] mask,
                          input logic mode, input logic [3:0] e_sel, input logic [2:0] e_ptr,
                          input logic e_found);
    int lat;
    way8   = vals;
    cond8  = mask;
    mode8  = mode;
    valid8 = 1'b1;
    accept8(name);
    valid8 = 1'b0;
    lat    = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (valid_out8) begin
        lat = n;
        break;
      end
    end
    check({name, "_lat"}, lat, 32'd3);
    check({name, "_sel"}, {28'd0, sel8}, {28'd0, e_sel});
    check({name, "_ptr"}, {29'd0, ptr8}, {29'd0, e_ptr});
    check({name, "_found"}, {31'd0, found8}, {31'd0, e_found});
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected to have finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat5;
    reset_in = 1'b1;
    valid8 = 1'b0; way8 = '0; cond8 = '0; mode8 = 1'b0; rdy8 = 1'b1;
    valid5 = 1'b0; way5 = '0; cond5 = '0; rdy5 = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'd0, ready_out8}, 32'd0);
    check("rst_valid", {31'd0, valid_out8}, 32'd0);
    check("rst_outs", {24'd0, found8, sel8, ptr8}, 32'd0);
    check("rst_valid5", {31'd0, valid_out5}, 32'd0);
    @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, ready_out8}, 32'd1);
    check("ready_after_rst5", {31'd0, ready_out5}, 32'd1);
    @(posedge clk);
    #1;

    run_one8("max_full",  32'h52709193, 8'hFF, 1'b0, 4'd9, 3'd1, 1'b1);
    run_one8("mask_zero", 32'h52709193, 8'h00, 1'b0, 4'd0, 3'd0, 1'b0);
    run_one8("tie_high",  32'h77777777, 8'hA0, 1'b0, 4'd7, 3'd5, 1'b1);
    run_one8("last_only", 32'h52709193, 8'h80, 1'b0, 4'd5, 3'd7, 1'b1);

    // 5-way: way 2 (value 15) is masked, ways 1 and 3 tie at 4.
    way5   = 20'h14F42;
    cond5  = 5'b11011;
    valid5 = 1'b1;
    @(negedge clk);
    check("w5_accept", {31'd0, ready_out5}, 32'd1);
    @(posedge clk);
    #1 valid5 = 1'b0;
    lat5 = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (valid_out5) begin
        lat5 = n;
        break;
      end
    end
    check("w5_lat", lat5, 32'd3);
    check("w5_sel", {28'd0, sel5}, 32'd4);
    check("w5_ptr", {29'd0, ptr5}, 32'd1);
    check("w5_found", {31'd0, found5}, 32'd1);
    @(posedge clk);
    #1;

`ifdef PIPELINED_ARGMAX_MIN_MODE_EN
    run_one8("min_f", 32'h00002826, 8'h0F, 1'b1, 4'd2, 3'd1, 1'b1);
    run_one8("min_d", 32'h00002826, 8'h0D, 1'b1, 4'd2, 3'd3, 1'b1);
    mode8 = 1'b0;
`endif

    // Back-to-back requests with the consumer stalled in cycles 4..6.
    fork
      begin
        for (int r = 0; r < 6; r++) begin
          way8   = bp_vals[r];
          cond8  = bp_masks[r];
          valid8 = 1'b1;
          accept8("bp_req");
        end
        valid8 = 1'b0;
      end
      begin
        for (int c = 0; c < 10; c++) begin
          rdy8 = !(c >= 4 && c <= 6);
          @(negedge clk);
          if (c >= 4 && c <= 6) check("bp_ready_low", {31'd0, ready_out8}, 32'd0);
          @(posedge clk);
          #1;
        end
        rdy8 = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("bp_drained", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;

    // Two requests in flight, then a one-cycle reset pulse.
    way8   = 32'h52709193;
    cond8  = 8'hFF;
    valid8 = 1'b1;
    @(negedge clk);
    check("rst_mid_acc", {31'd0, ready_out8}, 32'd1);
    @(posedge clk);
    #1 way8 = 32'h01234567;
    @(posedge clk);
    #1 valid8 = 1'b0;
    reset_in = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", {31'd0, ready_out8}, 32'd0);
    @(posedge clk);
    #1 reset_in = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", {31'd0, valid_out8}, 32'd0);
    check("rst_mid_ready1", {31'd0, ready_out8}, 32'd1);
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      check("rst_no_stale", {31'd0, valid_out8}, 32'd0);
    end
    @(posedge clk);
    #1;

    run_one8("post_rst", 32'h01234567, 8'hFF, 1'b0, 4'd7, 3'd0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
